// File: rtl/bp_common_pkg.sv
// Shared front-end/back-end interface definitions: FE queue entry layout and message-type encoding.
package bp_common_pkg;

  localparam int fe_queue_width_gp = 128;
  localparam int instr_width_gp    = 32;

  // The entry MSB tells a fetched instruction apart from an exception message.
  typedef enum logic {
    e_fe_exception = 1'b0,
    e_fe_fetch     = 1'b1
  } bp_fe_msg_type_e;

  typedef struct packed {
    bp_fe_msg_type_e                                   msg_type;
    logic [fe_queue_width_gp-instr_width_gp-2:0]       payload;
    logic [instr_width_gp-1:0]                         instr;
  } bp_fe_queue_s;

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Storage array with one synchronous write port and one asynchronous read port; contents are never reset.
module bsg_mem_1r1w #(
  parameter int width_p       = 128,
  parameter int els_p         = 8,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_fe_queue_checkpoint.sv
// FE queue with a speculative read pointer and a commit pointer, so the BE can replay
// issued-but-uncommitted entries by rolling back to the last commit point.
module bp_fe_queue_checkpoint
  import bp_common_pkg::*;
#(
  parameter int els_p         = 8,
  parameter int entry_width_p = 128,
  parameter int instr_lsb_p   = 0,
  parameter int type_bit_p    = 127
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [entry_width_p-1:0] fe_queue_i,
  input  logic                     fe_queue_v_i,
  output logic                     fe_queue_ready_o,

  output logic [entry_width_p-1:0] fe_queue_o,
  output logic                     fe_queue_v_o,
  input  logic                     fe_queue_yumi_i,

  input  logic                     fe_queue_clr_i,
  input  logic                     fe_queue_deq_i,
  input  logic                     fe_queue_roll_i,

  output logic [4:0]               rs1_addr_o,
  output logic [4:0]               rs2_addr_o,
  output logic                     rs1_v_o,
  output logic                     rs2_v_o,

  output logic [$clog2(els_p):0]   count_o
);

  localparam int ptr_w_lp  = $clog2(els_p) + 1;
  localparam int addr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp-1:0] els_lp = ptr_w_lp'(els_p);

  // Handshakes: enqueue fires on fe_queue_v_i & fe_queue_ready_o (ready never looks at valid);
  // the head is consumed on fe_queue_yumi_i & fe_queue_v_o; yumi with no valid head is ignored.
  logic [ptr_w_lp-1:0] wptr_r, rptr_r, cptr_r;
  logic [ptr_w_lp-1:0] cptr_n, rptr_n;
  logic                full, enq, yumi_fire, deq_fire;

  assign count_o          = wptr_r - cptr_r;
  assign full             = (count_o == els_lp);
  assign fe_queue_ready_o = ~full & ~fe_queue_clr_i;
  assign fe_queue_v_o     = (rptr_r != wptr_r);

  assign enq       = fe_queue_v_i & fe_queue_ready_o;
  assign yumi_fire = fe_queue_yumi_i & fe_queue_v_o;
  assign deq_fire  = fe_queue_deq_i & (cptr_r != rptr_r);

  // Roll rewinds to the commit point as it stands after this cycle's deq.
  assign cptr_n = cptr_r + ptr_w_lp'(deq_fire);
  assign rptr_n = fe_queue_roll_i ? cptr_n : (rptr_r + ptr_w_lp'(yumi_fire));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else if (fe_queue_clr_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cptr_r <= '0;
    end else begin
      wptr_r <= wptr_r + ptr_w_lp'(enq);
      rptr_r <= rptr_n;
      cptr_r <= cptr_n;
    end
  end

  bsg_mem_1r1w #(
    .width_p (entry_width_p),
    .els_p   (els_p)
  ) mem (
    .w_clk_i  (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wptr_r[addr_w_lp-1:0]),
    .w_data_i (fe_queue_i),
    .r_addr_i (rptr_r[addr_w_lp-1:0]),
    .r_data_o (fe_queue_o)
  );

  assign rs1_addr_o = fe_queue_o[instr_lsb_p+15 +: 5];
  assign rs2_addr_o = fe_queue_o[instr_lsb_p+20 +: 5];
  assign rs1_v_o    = fe_queue_v_o & (fe_queue_o[type_bit_p] == e_fe_fetch);
  assign rs2_v_o    = rs1_v_o;

endmodule

// File: tb/tb_bp_fe_queue_checkpoint.sv
// Bench for bp_fe_queue_checkpoint: queue-level reference model checked every cycle, plus directed scenarios.
module tb_bp_fe_queue_checkpoint;
  import bp_common_pkg::*;

  localparam int els_lp = 8;
  localparam int w_lp   = 128;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [w_lp-1:0] fe_queue_i;
  logic            fe_queue_v_i;
  logic            fe_queue_ready_o;
  logic [w_lp-1:0] fe_queue_o;
  logic            fe_queue_v_o;
  logic            fe_queue_yumi_i;
  logic            fe_queue_clr_i;
  logic            fe_queue_deq_i;
  logic            fe_queue_roll_i;
  logic [4:0]      rs1_addr_o, rs2_addr_o;
  logic            rs1_v_o, rs2_v_o;
  logic [3:0]      count_o;

  int checks = 0;
  int errors = 0;

  // Model: exp_q holds every uncommitted entry oldest-first; spec is how many of them
  // have been handed to the BE (the head is exp_q[spec]).
  logic [w_lp-1:0] exp_q[$];
  int              spec = 0;

  // clock / reset
  always #5 clk_i = ~clk_i;

  bp_fe_queue_checkpoint #(
    .els_p(els_lp), .entry_width_p(w_lp), .instr_lsb_p(0), .type_bit_p(127)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
    .fe_queue_o(fe_queue_o), .fe_queue_v_o(fe_queue_v_o), .fe_queue_yumi_i(fe_queue_yumi_i),
    .fe_queue_clr_i(fe_queue_clr_i), .fe_queue_deq_i(fe_queue_deq_i), .fe_queue_roll_i(fe_queue_roll_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rs1_v_o(rs1_v_o), .rs2_v_o(rs2_v_o),
    .count_o(count_o)
  );

  task automatic chk(input string name, input logic [w_lp-1:0] act, input logic [w_lp-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [w_lp-1:0] make_entry(input logic t, input logic [31:0] instr);
    bp_fe_queue_s s;
    s.msg_type = bp_fe_msg_type_e'(t);
    s.payload  = 95'({$urandom(), $urandom(), $urandom()});
    s.instr    = instr;
    return s;
  endfunction

  // reference model update
  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      exp_q.delete();
      spec = 0;
    end else if (fe_queue_clr_i) begin
      exp_q.delete();
      spec = 0;
    end else begin
      bit acc, yf, df;
      acc = fe_queue_v_i && (exp_q.size() < els_lp);
      yf  = fe_queue_yumi_i && (spec < exp_q.size());
      df  = fe_queue_deq_i && (spec > 0);
      if (df) void'(exp_q.pop_front());
      if (fe_queue_roll_i) spec = 0;
      else spec = spec + int'(yf) - int'(df);
      if (acc) exp_q.push_back(fe_queue_i);
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk_i) begin
    logic            ev;
    logic [w_lp-1:0] eh;
    ev = (spec < exp_q.size());
    chk("v_o", w_lp'(fe_queue_v_o), w_lp'(ev));
    chk("count_o", w_lp'(count_o), w_lp'(exp_q.size()));
    chk("ready_o", w_lp'(fe_queue_ready_o), w_lp'((exp_q.size() < els_lp) && !fe_queue_clr_i));
    if (ev) begin
      eh = exp_q[spec];
      chk("head", fe_queue_o, eh);
      chk("rs1_addr", w_lp'(rs1_addr_o), w_lp'(eh[19:15]));
      chk("rs2_addr", w_lp'(rs2_addr_o), w_lp'(eh[24:20]));
      chk("rs1_v", w_lp'(rs1_v_o), w_lp'(eh[127]));
      chk("rs2_v", w_lp'(rs2_v_o), w_lp'(eh[127]));
    end else begin
      chk("rs1_v_empty", w_lp'(rs1_v_o), '0);
      chk("rs2_v_empty", w_lp'(rs2_v_o), '0);
    end
  end

  // driver: inputs are applied just after a rising edge and held for one cycle
  task automatic drive(input logic v, input logic [w_lp-1:0] d, input logic y,
                       input logic dq, input logic rl, input logic cl);
    fe_queue_v_i    = v;
    fe_queue_i      = d;
    fe_queue_yumi_i = y;
    fe_queue_deq_i  = dq;
    fe_queue_roll_i = rl;
    fe_queue_clr_i  = cl;
    @(posedge clk_i);
    #1;
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    fe_queue_deq_i  = 1'b0;
    fe_queue_roll_i = 1'b0;
    fe_queue_clr_i  = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  logic [w_lp-1:0] a [9];
  logic [w_lp-1:0] e_add, e_exc;

  initial begin
    for (int i = 0; i < 9; i++) a[i] = make_entry(1'($urandom_range(0, 1)), $urandom());
    e_add = make_entry(1'b1, 32'h00B5_0533);
    e_exc = make_entry(1'b0, 32'h00B5_0533);

    reset_i = 1'b0;
    fe_queue_i = '0; fe_queue_v_i = 1'b0; fe_queue_yumi_i = 1'b0;
    fe_queue_clr_i = 1'b0; fe_queue_deq_i = 1'b0; fe_queue_roll_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_v", w_lp'(fe_queue_v_o), '0);
    chk("reset_count", w_lp'(count_o), '0);
    chk("reset_ready", w_lp'(fe_queue_ready_o), w_lp'(1));
    reset_i = 1'b1;

    // fill to capacity, then a ninth valid must bounce
    for (int i = 0; i < 8; i++) drive(1'b1, a[i], 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_ready", w_lp'(fe_queue_ready_o), '0);
    chk("full_count", w_lp'(count_o), w_lp'(8));
    drive(1'b1, a[8], 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ninth_count", w_lp'(count_o), w_lp'(8));
    chk("ninth_head", fe_queue_o, a[0]);

    // yumi 3, deq 1, roll -> replay from A1
    clear();
    for (int i = 0; i < 4; i++) drive(1'b1, a[i], 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("roll_head", fe_queue_o, a[1]);
    chk("roll_count", w_lp'(count_o), w_lp'(3));
    chk("roll_v", w_lp'(fe_queue_v_o), w_lp'(1));

    // roll and deq together with cptr=0, rptr=2
    clear();
    for (int i = 0; i < 4; i++) drive(1'b1, a[i], 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rolldeq_head", fe_queue_o, a[1]);
    chk("rolldeq_count", w_lp'(count_o), w_lp'(3));

    // clr wins over a simultaneous enqueue
    clear();
    drive(1'b1, a[0], 1'b0, 1'b0, 1'b0, 1'b0);
    fe_queue_clr_i = 1'b1;
    #1;
    chk("clr_ready", w_lp'(fe_queue_ready_o), '0);
    drive(1'b1, a[5], 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_v", w_lp'(fe_queue_v_o), '0);
    chk("clr_count", w_lp'(count_o), '0);
    idle();
    chk("clr_b0_absent", w_lp'(fe_queue_v_o), '0);

    // source-register decode: add x10,x10,x11 then an exception entry
    drive(1'b1, e_add, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add_rs1", w_lp'(rs1_addr_o), w_lp'(10));
    chk("add_rs2", w_lp'(rs2_addr_o), w_lp'(11));
    chk("add_rs1_v", w_lp'(rs1_v_o), w_lp'(1));
    chk("add_rs2_v", w_lp'(rs2_v_o), w_lp'(1));
    drive(1'b1, e_exc, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("exc_v", w_lp'(fe_queue_v_o), w_lp'(1));
    chk("exc_rs1_v", w_lp'(rs1_v_o), '0);

    // randomized traffic through many pointer wraps
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 2) != 0),
            make_entry(1'($urandom_range(0, 1)), $urandom()),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 39) == 0));
    end

    // steady enqueue/yumi/deq across the wrap, then asynchronous reset mid-stream
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, make_entry(1'b1, $urandom()), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    fe_queue_v_i = 1'b1;
    fe_queue_i = make_entry(1'b1, $urandom());
    fe_queue_yumi_i = 1'b1;
    fe_queue_deq_i = 1'b1;
    #2;
    reset_i = 1'b0;
    #1;
    chk("async_v", w_lp'(fe_queue_v_o), '0);
    chk("async_count", w_lp'(count_o), '0);
    chk("async_rs1_v", w_lp'(rs1_v_o), '0);
    chk("async_ready", w_lp'(fe_queue_ready_o), w_lp'(1));
    @(posedge clk_i);
    #1;
    fe_queue_v_i = 1'b0;
    fe_queue_yumi_i = 1'b0;
    fe_queue_deq_i = 1'b0;
    reset_i = 1'b1;
    idle();
    chk("post_reset_v", w_lp'(fe_queue_v_o), '0);
    drive(1'b1, a[2], 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_head", fe_queue_o, a[2]);
    chk("post_reset_count", w_lp'(count_o), w_lp'(1));
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_queue_checkpoint.md
BP_FE_QUEUE_CHECKPOINT -- requirements
Module: bp_fe_queue_checkpoint

Interface
REQ-001 SHALL have parameter els_p, default 8: entry count; power of two, at least 2.
REQ-002 SHALL have parameter entry_width_p, default 128: FE queue entry width in bits.
REQ-003 SHALL have parameter instr_lsb_p, default 0: bit position of instruction bit 0 within an entry.
REQ-004 SHALL have parameter type_bit_p, default 127: entry bit that marks an instruction (1) versus an exception message (0).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port reset_i, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports fe_queue_i (in, entry_width_p), fe_queue_v_i (in, 1) and fe_queue_ready_o (out, 1): the enqueue side from the FE.
REQ-008 SHALL have ports fe_queue_o (out, entry_width_p), fe_queue_v_o (out, 1) and fe_queue_yumi_i (in, 1): the head entry offered to the BE checker.
REQ-009 SHALL have inputs fe_queue_clr_i, fe_queue_deq_i and fe_queue_roll_i, each 1 bit: the BE control inputs.
REQ-010 SHALL have outputs rs1_addr_o and rs2_addr_o (5 bits each) and rs1_v_o and rs2_v_o (1 bit each): head-entry source registers.
REQ-011 SHALL have output count_o, $clog2(els_p)+1 bits: the number of uncommitted entries.

Function
REQ-012 SHALL keep three pointers, each $clog2(els_p)+1 bits with a wrap bit: wptr (write), rptr (speculative read) and cptr (commit).
REQ-013 SHALL compute count_o as wptr-cptr modulo 2^($clog2(els_p)+1).
REQ-014 SHALL signal full when count_o==els_p.
REQ-015 SHALL drive fe_queue_ready_o = ~full & ~fe_queue_clr_i, with no dependence on fe_queue_v_i.
REQ-016 SHALL, on fe_queue_v_i & fe_queue_ready_o, write the entry at wptr and increment wptr by 1.
REQ-017 SHALL make a written entry visible at the head no earlier than the next cycle; there is no same-cycle bypass.
REQ-018 SHALL drive fe_queue_v_o = (rptr!=wptr) and fe_queue_o = mem[rptr], combinationally from state.
REQ-019 SHALL advance rptr by 1 on fe_queue_yumi_i & fe_queue_v_o, and SHALL ignore yumi when fe_queue_v_o=0.
REQ-020 SHALL advance cptr by 1 on fe_queue_deq_i when cptr!=rptr, and SHALL ignore deq when cptr==rptr.
REQ-021 SHALL, on fe_queue_roll_i, load rptr with the post-deq value of cptr, so that roll plus deq in the same cycle gives rptr=cptr+1; a yumi in the same cycle is ignored.
REQ-022 SHALL, on fe_queue_clr_i, zero all three pointers next cycle; clr overrides enqueue, yumi, deq and roll in that cycle.
REQ-023 SHALL free an entry only when cptr passes it; entries between cptr and rptr remain replayable.
REQ-024 SHALL allow enqueue, yumi and deq in the same cycle, each taking effect independently.
REQ-025 SHALL set rs1_addr_o = instr[19:15] and rs2_addr_o = instr[24:20] of the head entry.
REQ-026 SHALL drive rs1_v_o = rs2_v_o = fe_queue_v_o & entry[type_bit_p].
REQ-027 SHALL wrap all pointers modulo 2*els_p; the low bits index storage and the MSB distinguishes full from empty.

Reset
REQ-028 SHALL, while reset_i=0 and independent of clk_i, zero all pointers.
REQ-029 SHALL, while reset_i=0, hold fe_queue_v_o=0, rs1_v_o=0, rs2_v_o=0 and count_o=0, and hold fe_queue_ready_o=1 unless fe_queue_clr_i=1.
REQ-030 SHALL NOT reset the storage contents.
REQ-031 SHALL, when reset is asserted mid-operation, drop every pending entry.

Structure
REQ-032 SHALL take the FE queue entry typedef and the message-type encoding from bp_common_pkg (fe_be_if), not define them locally.
REQ-033 SHALL hold the storage in one sub-module, bsg_mem_1r1w (els_p x entry_width_p), with an asynchronous read and a synchronous write.
REQ-034 SHALL implement the pointer and control logic in this module; no further sub-modules.

Verification
REQ-035 SHALL be checked by: enqueue 8 entries A0..A7 with no yumi -> ready_o=0 and count_o=8 on the cycle after the 8th; a 9th valid is not accepted.
REQ-036 SHALL be checked by: enqueue A0..A3; yumi 3; deq 1; roll -> head=A1 next cycle, count_o=3, v_o=1.
REQ-037 SHALL be checked by: roll and deq together with cptr=0 and rptr=2 -> rptr=1, head=A1.
REQ-038 SHALL be checked by: clr together with enqueue of B0 -> next cycle v_o=0, count_o=0, B0 absent.
REQ-039 SHALL be checked by: head instruction 0x00B50533 (add x10,x10,x11) -> rs1_addr_o=10, rs2_addr_o=11, rs1_v_o=rs2_v_o=1; an exception entry at the head -> rs1_v_o=0.
REQ-040 SHALL be checked by: 20 enqueue/yumi/deq cycles across the wrap boundary, then reset_i=0 mid-stream -> outputs reach reset values asynchronously, with no spurious full or empty state after pointer wrap.
